eth_10g_mac_tx_frame_skid_adapter: RTL



---
 rtl/eth_10g_mac_tx_frame_skid_adapter.sv | 107 ++++++++++
 1 files changed

// File: rtl/eth_10g_mac_tx_frame_skid_adapter.sv
// TX client to 10G MAC frame adapter: 2-entry registered skid buffer with
// a framing FSM that repairs sop/eop violations and counts them.
module eth_10g_mac_tx_frame_skid_adapter #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned EMPTY_WIDTH = 3,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   in_ready,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_error,
  input  logic                   in_startofpacket,
  input  logic                   in_endofpacket,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_error,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  input  logic                   out_ready,
  output logic [CNT_WIDTH-1:0]   drop_count,
  output logic [CNT_WIDTH-1:0]   frame_err_count
);

  localparam int unsigned PAYLOAD_WIDTH = DATA_WIDTH + EMPTY_WIDTH + 3;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t                   state;
  logic [1:0]               count;
  logic [1:0]               count_next;
  logic [PAYLOAD_WIDTH-1:0] head;
  logic [PAYLOAD_WIDTH-1:0] skid;
  logic [PAYLOAD_WIDTH-1:0] beat;
  logic                     accept;
  logic                     pop;
  logic                     store;
  logic                     drop;
  logic                     frame_err;

  // Beat classification and repaired payload for the accepted beat
  always_comb begin
    accept     = in_valid & in_ready;
    pop        = out_valid & out_ready;
    store      = accept & ((state == IN_PKT) | in_startofpacket);
    drop       = accept & (state == IDLE) & ~in_startofpacket;
    frame_err  = accept & (state == IN_PKT) & in_startofpacket;
    beat       = {in_data,
                  in_error | ((state == IN_PKT) & in_startofpacket),
                  in_startofpacket & (state == IDLE),
                  in_endofpacket,
                  in_endofpacket ? in_empty : EMPTY_WIDTH'(0)};
    count_next = count + 2'(store) - 2'(pop);
  end

  assign {out_data, out_error, out_startofpacket, out_endofpacket, out_empty} = head;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      count           <= 2'd0;
      in_ready        <= 1'b0;
      out_valid       <= 1'b0;
      head            <= '0;
      skid            <= '0;
      drop_count      <= '0;
      frame_err_count <= '0;
    end else begin
      count     <= count_next;
      in_ready  <= (count_next != 2'd2);
      out_valid <= (count_next != 2'd0);

      // Framing FSM advances only on accepted beats
      if (accept) begin
        case (state)
          IDLE:    if (in_startofpacket && !in_endofpacket) state <= IN_PKT;
          IN_PKT:  if (in_endofpacket) state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      // Head is refilled from the skid entry, or directly when it is free
      if (pop && count == 2'd2) begin
        head <= skid;
      end else if (store && (count == 2'd0 || (count == 2'd1 && pop))) begin
        head <= beat;
      end
      if (store && count == 2'd1 && !pop) begin
        skid <= beat;
      end

      if (drop && drop_count != '1) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
      if (frame_err && frame_err_count != '1) begin
        frame_err_count <= frame_err_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
